rr_reg_arbiter: RTL and testbench
=================================

// Module: rr_reg_arbiter
// PURPOSE
//  Round-robin arbiter sharing one WIDTH-bit enable register (DFFE-style, clock-enabled
//  storage) between N requesters. Grants exclusive write ownership via req/gnt handshake,
//  muxes the owner's data onto the register, and bounds each tenure to HOLD_MAX beats.
//  Sits between register-file clients and the shared primitive storage in Primitives.
// PARAMETERS
//  N        4  number of requesters (>=2)
//  WIDTH    8  data/register width in bits
//  HOLD_MAX 4  max write beats per grant before forced release (>=1)
// PORTS
//  clk       in   1         system clock, all logic on rising edge
//  reset     in   1         synchronous reset, active-high
//  req       in   N         request/hold ownership, one bit per requester
//  wr_valid  in   N         write beat strobe, honoured only for current owner
//  wr_data   in   N*WIDTH   requester k data in bits [k*WIDTH +: WIDTH]
//  gnt       out  N         one-hot grant, registered
//  owner     out  clog2(N)  index of current owner, valid while busy
//  busy      out  1         high while in GRANT state
//  q         out  WIDTH     shared register contents
//  revoked   out  1         1-cycle pulse: grant ended by HOLD_MAX, not by release
// BEHAVIOUR
//  Interface: one clock (clk); reset is synchronous and active-high (reset).
//  Reset (edge with reset=1, any state, incl. mid-grant): state=IDLE, gnt=0, owner=0,
//   busy=0, q=0, revoked=0, rr pointer ptr=0, beat count=0. Pending writes dropped.
//  FSM: IDLE, GRANT.
//  IDLE: if |req at edge -> pick first k with req[k]=1 searching ptr, ptr+1, ... mod N;
//   gnt<=onehot(k), owner<=k, ptr<=(k+1) mod N, beats<=0, state<=GRANT.
//   Latency req->gnt: 1 cycle. No req -> stay IDLE, outputs hold.
//  GRANT (owner k):
//   - beat: gnt[k]&wr_valid[k] at edge -> q<=wr_data[k], beats<=beats+1; q visible next
//     cycle. wr_valid of non-owners ignored, q unaffected.
//   - release: req[k]=0 at edge -> gnt<=0, state<=IDLE; wr_valid[k] on that same edge
//     is still written (release and last beat may coincide).
//   - revoke: edge where beat makes beats==HOLD_MAX -> that beat written, gnt<=0,
//     state<=IDLE, revoked<=1 for one cycle. Release on same edge takes precedence:
//     no revoked pulse.
//   - requester keeping req high after revoke re-competes normally; ptr already
//     moved past it, so other pending requesters are served first.
//  Grant gap: exactly one IDLE cycle between consecutive grants (gnt=0 for >=1 cycle).
//  Fairness: with all req held, grant order 0,1,..,N-1,0,... each tenure <=HOLD_MAX beats.
//  ptr wraps N-1 -> 0; beats counter width clog2(HOLD_MAX+1), never exceeds HOLD_MAX.
//  q holds value indefinitely when no beat; never X after reset.
//  gnt always one-hot or zero; busy == |gnt; owner held after release until next grant.
// TESTING
//  1 reset=1 2 cycles, then idle 3 cycles -> gnt=0, busy=0, q=8'h00, revoked=0.
//  2 req=4'b0010, wr_valid[1]=1 data 8'hA5 for 2 cycles, then req=0 -> gnt=4'b0010 1 cycle
//    after req, q=8'hA5, gnt=0 after release, busy drops, no revoked pulse.
//  3 req=4'b1111 held, all wr_valid=1, data k=8'h10+k -> grants 0,1,2,3,0, each 4 beats,
//    revoked pulse after each tenure, 1-cycle gnt gap, q steps 10,11,12,13.
//  4 owner=2, wr_valid[0]=1 data 8'hFF while wr_valid[2]=0 -> q unchanged, gnt stays 4'b0100.
//  5 owner=1 after 2 beats, reset=1 one cycle -> next cycle gnt=0, q=0, busy=0; req=4'b0010
//    held -> regrant to 1 one cycle after reset drops (ptr=0 search).
//  6 HOLD_MAX=4, owner drops req on 4th beat edge -> beat written, gnt=0, revoked stays 0.

Source files
------------

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter granting N requesters exclusive write ownership of one
// shared WIDTH-bit clock-enabled register, with tenure bounded to HOLD_MAX beats.
module rr_reg_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [N-1:0]                        i_req,
    input  logic [N-1:0]                        i_wr_valid,
    input  logic [N*WIDTH-1:0]                  i_wr_data,
    output logic [N-1:0]                        o_gnt,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0]  o_owner,
    output logic                                o_busy,
    output logic [WIDTH-1:0]                    o_q,
    output logic                                o_revoked
);
    localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW = $clog2(HOLD_MAX + 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [N-1:0]      r_gnt, w_gnt_nxt;
    logic [OW-1:0]     r_owner, w_owner_nxt;
    logic [OW-1:0]     r_ptr, w_ptr_nxt;
    logic [BW-1:0]     r_beats, w_beats_nxt;
    logic              r_busy, w_busy_nxt;
    logic [WIDTH-1:0]  r_q, w_q_nxt;
    logic              r_revoked, w_revoked_nxt;

    logic              w_own_req, w_own_valid, w_found, w_revoke;
    logic [WIDTH-1:0]  w_own_data;
    logic [OW-1:0]     w_pick;

    // Current owner's request, strobe and data lines.
    always_comb begin
        w_own_req   = 1'b0;
        w_own_valid = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (OW'(i) == r_owner) begin
                w_own_req   = i_req[i];
                w_own_valid = i_wr_valid[i];
                w_own_data  = i_wr_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // First requester at or after the rotating pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (!w_found && i_req[(int'(r_ptr) + i) % int'(N)]) begin
                w_found = 1'b1;
                w_pick  = OW'((int'(r_ptr) + i) % int'(N));
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_owner_nxt   = r_owner;
        w_ptr_nxt     = r_ptr;
        w_beats_nxt   = r_beats;
        w_busy_nxt    = r_busy;
        w_q_nxt       = r_q;
        w_revoked_nxt = 1'b0;
        w_revoke      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_pick;
                    w_owner_nxt = w_pick;
                    w_ptr_nxt   = OW'((int'(w_pick) + 1) % int'(N));
                    w_beats_nxt = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_GRANT: begin
                if (w_own_valid) begin
                    w_q_nxt     = w_own_data;
                    w_beats_nxt = r_beats + BW'(1);
                    w_revoke    = (r_beats == BW'(HOLD_MAX - 1));
                end
                // Voluntary release outranks revoke on the same edge.
                if (!w_own_req || w_revoke) begin
                    w_state_nxt   = S_IDLE;
                    w_gnt_nxt     = '0;
                    w_busy_nxt    = 1'b0;
                    w_revoked_nxt = w_own_req;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_beats   <= '0;
            r_busy    <= 1'b0;
            r_q       <= '0;
            r_revoked <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_beats   <= w_beats_nxt;
            r_busy    <= w_busy_nxt;
            r_q       <= w_q_nxt;
            r_revoked <= w_revoked_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_owner   = r_owner;
    assign o_busy    = r_busy;
    assign o_q       = r_q;
    assign o_revoked = r_revoked;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: directed scenarios followed by random traffic,
// all checked against a tenure-level reference model of the arbiter.
module tb_rr_reg_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, wr_valid;
    logic [N*W-1:0] wr_data;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic           busy, revoked;
    logic [W-1:0]   q;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the register, where the search starts next,
    // how many beats the owner has used, and the register value.
    int       m_owner, m_ptr, m_beats;
    bit       m_busy, m_rev;
    logic [W-1:0] m_q;

    rr_reg_arbiter #(.N(N), .WIDTH(W), .HOLD_MAX(H)) dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_wr_valid(wr_valid),
        .i_wr_data(wr_data), .o_gnt(gnt), .o_owner(owner), .o_busy(busy),
        .o_q(q), .o_revoked(revoked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge();
        m_rev = 1'b0;
        if (reset) begin
            m_owner = 0; m_ptr = 0; m_beats = 0; m_busy = 0; m_q = '0;
        end else if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (!m_busy && req[k]) begin
                    m_busy = 1; m_owner = k; m_ptr = (k + 1) % N; m_beats = 0;
                end
            end
        end else begin
            if (wr_valid[m_owner]) begin
                m_q = wr_data[m_owner*W +: W];
                m_beats++;
            end
            if (!req[m_owner]) m_busy = 0;
            else if (m_beats == H) begin
                m_busy = 0; m_rev = 1;
            end
        end
    endfunction

    task automatic step(input string tag);
        logic [N-1:0] eg;
        model_edge();
        @(posedge clk);
        #1;
        eg = m_busy ? N'(1) << m_owner : '0;
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".revoked"}, 32'(revoked), 32'(m_rev));
    endtask

    task automatic set_data(input int k, input logic [W-1:0] v);
        wr_data[k*W +: W] = v;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) step("rst");
        reset = 1'b0;
    endtask

    initial begin
        int waited;
        reset = 1'b0; req = '0; wr_valid = '0; wr_data = '0;
        m_owner = 0; m_ptr = 0; m_beats = 0; m_busy = 0; m_q = '0; m_rev = 0;

        // 1: reset then idle
        do_reset(2);
        for (int i = 0; i < 3; i++) step("idle");
        chk("idle.q_zero", 32'(q), 32'h00);

        // 2: single requester, two beats, release
        req = 4'b0010; wr_valid = 4'b0010; set_data(1, 8'hA5);
        step("t2.grant");
        chk("t2.gnt1", 32'(gnt), 32'h2);
        step("t2.beat1");
        step("t2.beat2");
        chk("t2.q", 32'(q), 32'hA5);
        req = '0; wr_valid = '0;
        step("t2.release");
        chk("t2.gnt0", 32'(gnt), 32'h0);
        chk("t2.norev", 32'(revoked), 32'h0);
        step("t2.after");

        // 3: all requesting, all writing -> revoke-driven rotation
        do_reset(1);
        req = 4'b1111; wr_valid = 4'b1111;
        for (int k = 0; k < N; k++) set_data(k, W'(8'h10 + k));
        for (int c = 0; c < 5 * (H + 2); c++) step("t3.rr");
        req = '0; wr_valid = '0;
        step("t3.drain");
        step("t3.idle");

        // 4: owner 2, non-owner strobe ignored
        do_reset(1);
        req = 4'b0100;
        step("t4.grant");
        wr_valid = 4'b0001; set_data(0, 8'hFF);
        step("t4.foreign1");
        step("t4.foreign2");
        chk("t4.gnt", 32'(gnt), 32'h4);
        chk("t4.q", 32'(q), 32'h0);
        wr_valid = '0; req = '0;
        step("t4.release");

        // 5: reset mid-grant, then regrant from ptr=0
        do_reset(1);
        req = 4'b0010; wr_valid = 4'b0010; set_data(1, 8'h3C);
        step("t5.grant");
        step("t5.beat1");
        step("t5.beat2");
        wr_valid = '0;
        do_reset(1);
        chk("t5.rst_gnt", 32'(gnt), 32'h0);
        chk("t5.rst_q", 32'(q), 32'h0);
        step("t5.regrant");
        chk("t5.regnt", 32'(gnt), 32'h2);
        req = '0;
        step("t5.release");

        // 6: release coinciding with the HOLD_MAX-th beat
        do_reset(1);
        req = 4'b0001; wr_valid = 4'b0001;
        step("t6.grant");
        for (int b = 1; b < H; b++) begin
            set_data(0, W'(8'h60 + b));
            step("t6.beat");
        end
        set_data(0, 8'h6F); req = '0;
        step("t6.last");
        chk("t6.q", 32'(q), 32'h6F);
        chk("t6.norev", 32'(revoked), 32'h0);
        wr_valid = '0;
        step("t6.idle");

        // Bounded wait for a grant after a fresh request
        req = 4'b1000; waited = 0;
        while (gnt == '0 && waited < 10) begin
            step("wait");
            waited++;
        end
        chk("wait.bounded", 32'(gnt), 32'h8);
        req = '0;
        step("wait.rel");

        // Random traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 59) == 0);
            req      = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) req = req | (m_busy ? N'(1) << m_owner : '0);
            wr_valid = N'($urandom_range(0, 15));
            wr_data  = 32'($urandom);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
